// File: rtl/wb_timer_pkg.sv
// Shared register map, CTRL bit positions and byte-lane merge helper for wb_timer.
package wb_timer_pkg;

   localparam logic [2:0] ADDR_CTRL     = 3'd0;
   localparam logic [2:0] ADDR_PRESCALE = 3'd1;
   localparam logic [2:0] ADDR_RELOAD   = 3'd2;
   localparam logic [2:0] ADDR_COUNT    = 3'd3;
   localparam logic [2:0] ADDR_STATUS   = 3'd4;

   localparam int CTRL_EN     = 0;
   localparam int CTRL_AUTO   = 1;
   localparam int CTRL_IRQ_EN = 2;

   // Replaces only the bytes whose select bit is set; the rest keep the old value.
   function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  sel);
      logic [31:0] res;
      res = old_v;
      for (int b = 0; b < 4; b++) begin
         if (sel[b]) res[8*b +: 8] = new_v[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/wb_timer_if.sv
// Wishbone classic slave-side bus bundle for wb_timer (clock and reset stay separate).
interface wb_timer_if;

   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic [31:0] wbs_dat_o;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic        wbs_stb_i;
   logic        wbs_cyc_i;
   logic        wbs_ack_o;

   modport master (
      output wbs_adr_i, wbs_dat_i, wbs_we_i, wbs_sel_i, wbs_stb_i, wbs_cyc_i,
      input  wbs_dat_o, wbs_ack_o
   );

   modport slave (
      input  wbs_adr_i, wbs_dat_i, wbs_we_i, wbs_sel_i, wbs_stb_i, wbs_cyc_i,
      output wbs_dat_o, wbs_ack_o
   );

endinterface

// File: rtl/wb_timer_prescaler.sv
// Clock divider for wb_timer: free-running pcnt that emits a one-cycle tick every div+1 enabled clocks.
module wb_timer_prescaler #(
   parameter int PRESCALE_W = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  clr,
   input  logic [PRESCALE_W-1:0] div,
   output logic                  tick
);

   logic [PRESCALE_W-1:0] r_pcnt;
   logic                  w_wrap;

   assign w_wrap = (r_pcnt == div);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pcnt <= '0;
      end else if (!en || clr || w_wrap) begin
         r_pcnt <= '0;
      end else begin
         r_pcnt <= r_pcnt + 1'b1;
      end
   end

   // A prescale rewrite restarts the period, so no tick escapes in that cycle.
   assign tick = en & ~clr & w_wrap;

endmodule

// File: rtl/wb_timer.sv
// Wishbone classic 32-bit down-counting timer with prescaler, optional auto-reload and level irq.
module wb_timer
   import wb_timer_pkg::*;
#(
   parameter int PRESCALE_W = 16
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   wb_timer_if.slave   wbs,
   output logic        irq_o
);

   logic                  r_ack;
   logic [31:0]           r_dat;
   logic                  r_en;
   logic                  r_auto;
   logic                  r_irq_en;
   logic [PRESCALE_W-1:0] r_prescale;
   logic [31:0]           r_reload;
   logic [31:0]           r_count;
   logic                  r_expired;

   logic        w_req;
   logic        w_wr;
   logic        w_rd;
   logic [2:0]  w_addr;
   logic [31:0] w_rdata;
   logic [31:0] w_merged;
   logic        w_wr_ctrl;
   logic        w_wr_prescale;
   logic        w_wr_reload;
   logic        w_wr_count;
   logic        w_wr_status;
   logic        w_tick;
   logic        w_expire;
   logic        w_unused;

   assign w_addr   = wbs.wbs_adr_i[4:2];
   assign w_unused = ^{wbs.wbs_adr_i[31:5], wbs.wbs_adr_i[1:0]};

   // Gating with ~r_ack makes every request take exactly one ack cycle.
   assign w_req = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~r_ack;
   assign w_wr  = w_req &  wbs.wbs_we_i;
   assign w_rd  = w_req & ~wbs.wbs_we_i;

   assign w_wr_ctrl     = w_wr && (w_addr == ADDR_CTRL);
   assign w_wr_prescale = w_wr && (w_addr == ADDR_PRESCALE);
   assign w_wr_reload   = w_wr && (w_addr == ADDR_RELOAD);
   assign w_wr_count    = w_wr && (w_addr == ADDR_COUNT);
   assign w_wr_status   = w_wr && (w_addr == ADDR_STATUS);

   always_comb begin
      w_rdata = '0;
      case (w_addr)
         ADDR_CTRL:     w_rdata = {29'd0, r_irq_en, r_auto, r_en};
         ADDR_PRESCALE: w_rdata = 32'(r_prescale);
         ADDR_RELOAD:   w_rdata = r_reload;
         ADDR_COUNT:    w_rdata = r_count;
         ADDR_STATUS:   w_rdata = {31'd0, r_expired};
         default:       w_rdata = '0;
      endcase
   end

   // The current register value doubles as the base for partial byte-lane writes.
   assign w_merged = lane_merge(w_rdata, wbs.wbs_dat_i, wbs.wbs_sel_i);

   wb_timer_prescaler #(
      .PRESCALE_W (PRESCALE_W)
   ) u_prescaler (
      .clk   (wb_clk_i),
      .rst_n (wb_rst_i),
      .en    (r_en),
      .clr   (w_wr_prescale),
      .div   (r_prescale),
      .tick  (w_tick)
   );

   assign w_expire = w_tick && (r_count == 32'd0);

   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         r_ack <= 1'b0;
         r_dat <= '0;
      end else begin
         r_ack <= w_req;
         r_dat <= w_rd ? w_rdata : 32'd0;
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         r_en       <= 1'b0;
         r_auto     <= 1'b0;
         r_irq_en   <= 1'b0;
         r_prescale <= '0;
         r_reload   <= '0;
      end else begin
         // EN is only overridden by the bus when its byte lane is actually written.
         if (w_wr_ctrl && wbs.wbs_sel_i[0]) begin
            r_en <= wbs.wbs_dat_i[CTRL_EN];
         end else if (w_expire && !r_auto) begin
            r_en <= 1'b0;
         end
         if (w_wr_ctrl) begin
            r_auto   <= w_merged[CTRL_AUTO];
            r_irq_en <= w_merged[CTRL_IRQ_EN];
         end
         if (w_wr_prescale) r_prescale <= w_merged[PRESCALE_W-1:0];
         if (w_wr_reload)   r_reload   <= w_merged;
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         r_count <= '0;
      end else if (w_wr_count) begin
         r_count <= w_merged;
      end else if (w_tick) begin
         if (r_count != 32'd0) begin
            r_count <= r_count - 32'd1;
         end else if (r_auto) begin
            r_count <= r_reload;
         end
      end
   end

   // A fresh expiry outranks a simultaneous software clear.
   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         r_expired <= 1'b0;
      end else if (w_expire) begin
         r_expired <= 1'b1;
      end else if (w_wr_status && wbs.wbs_sel_i[0] && wbs.wbs_dat_i[0]) begin
         r_expired <= 1'b0;
      end
   end

   assign wbs.wbs_ack_o = r_ack;
   assign wbs.wbs_dat_o = r_dat;
   assign irq_o         = r_expired & r_irq_en;

endmodule

// File: tb/tb_wb_timer.sv
// Directed bench for wb_timer: register table plus timed sequences for tick, expiry and reset corners.
module tb_wb_timer;

   logic clk;
   logic rst_n;
   logic irq;

   wb_timer_if bus ();

   wb_timer #(
      .PRESCALE_W (16)
   ) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst_n),
      .wbs      (bus),
      .irq_o    (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[19];
   int   n_checks;
   int   n_errors;

   function automatic vec_t mk(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                               input logic [3:0] sel, input logic [31:0] exp);
      vec_t v;
      v.we  = we;
      v.adr = adr;
      v.dat = dat;
      v.sel = sel;
      v.exp = exp;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One bus transfer: commit edge, then an idle edge so the next request can be acked again.
   task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, output logic [31:0] rdata);
      @(negedge clk);
      bus.wbs_cyc_i = 1'b1;
      bus.wbs_stb_i = 1'b1;
      bus.wbs_we_i  = we;
      bus.wbs_adr_i = adr;
      bus.wbs_dat_i = dat;
      bus.wbs_sel_i = sel;
      @(posedge clk);
      #1;
      check("ack_after_1", 32'(bus.wbs_ack_o), 32'd1);
      rdata = bus.wbs_dat_o;
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
      bus.wbs_we_i  = 1'b0;
      @(posedge clk);
      #1;
      check("idle_ack_dat", {bus.wbs_dat_o[30:0], bus.wbs_ack_o}, 32'd0);
   endtask

   task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
      logic [31:0] d;
      xfer(1'b1, adr, dat, 4'hF, d);
   endtask

   task automatic rd(input string name, input logic [31:0] adr, input logic [31:0] exp);
      logic [31:0] d;
      xfer(1'b0, adr, 32'd0, 4'hF, d);
      check(name, d, exp);
   endtask

   // Counts rising edges until irq goes high, giving up after a fixed budget.
   task automatic wait_irq(input string name, input int first, input int expect_edges);
      int edges;
      edges = -1;
      for (int k = first; k <= first + 40; k++) begin
         @(posedge clk);
         #1;
         if (irq) begin
            edges = k;
            break;
         end
      end
      check(name, 32'(edges), 32'(expect_edges));
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      n_checks = 0;
      n_errors = 0;

      for (int i = 0; i < 8; i++) vecs[i] = mk(1'b0, 32'(i * 4), 32'd0, 4'hF, 32'd0);
      vecs[8]  = mk(1'b1, 32'h04, 32'hFFFF_FFFF, 4'hF, 32'd0);
      vecs[9]  = mk(1'b0, 32'h04, 32'd0,         4'hF, 32'h0000_FFFF);
      vecs[10] = mk(1'b1, 32'h04, 32'h1234_0003, 4'h1, 32'd0);
      vecs[11] = mk(1'b0, 32'h04, 32'd0,         4'hF, 32'h0000_FF03);
      vecs[12] = mk(1'b1, 32'h18, 32'hFFFF_FFFF, 4'hF, 32'd0);
      vecs[13] = mk(1'b0, 32'h18, 32'd0,         4'hF, 32'd0);
      vecs[14] = mk(1'b1, 32'h00, 32'hFFFF_FFF8, 4'hF, 32'd0);
      vecs[15] = mk(1'b0, 32'h00, 32'd0,         4'hF, 32'd0);
      vecs[16] = mk(1'b1, 32'h0C, 32'hDEAD_BEEF, 4'hF, 32'd0);
      vecs[17] = mk(1'b0, 32'h0C, 32'd0,         4'hF, 32'hDEAD_BEEF);
      vecs[18] = mk(1'b0, 32'h10, 32'd0,         4'hF, 32'd0);

      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
      bus.wbs_we_i  = 1'b0;
      bus.wbs_adr_i = '0;
      bus.wbs_dat_i = '0;
      bus.wbs_sel_i = '0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_ack_irq", {bus.wbs_dat_o[29:0], bus.wbs_ack_o, irq}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 19; i++) begin
         xfer(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, d);
         if (!vecs[i].we) check($sformatf("vec%0d_rd", i), d, vecs[i].exp);
      end
      check("irq_after_table", 32'(irq), 32'd0);

      // One-shot: prescale 3, count 2 -> expiry 12 clocks after CTRL commits.
      wr(32'h04, 32'h0000_0003);
      wr(32'h0C, 32'h0000_0002);
      wr(32'h00, 32'h0000_0005);
      check("oneshot_irq_early", 32'(irq), 32'd0);
      wait_irq("oneshot_irq_delay", 2, 12);
      rd("oneshot_ctrl_en_cleared", 32'h00, 32'h0000_0004);
      rd("oneshot_count_zero", 32'h0C, 32'd0);
      rd("oneshot_status", 32'h10, 32'd1);

      // Auto-reload with prescale 0: period 6 clocks.
      wr(32'h10, 32'd1);
      check("status_clear_irq", 32'(irq), 32'd0);
      wr(32'h08, 32'd5);
      wr(32'h04, 32'd0);
      wr(32'h00, 32'h0000_0007);
      check("auto_irq_first", 32'(irq), 32'd1);
      wr(32'h10, 32'd1);
      check("auto_irq_cleared", 32'(irq), 32'd0);
      wait_irq("auto_reexpire", 1, 4);
      rd("auto_count_a", 32'h0C, 32'd5);
      rd("auto_count_b", 32'h0C, 32'd3);
      rd("auto_count_c", 32'h0C, 32'd1);
      rd("auto_count_d", 32'h0C, 32'd5);
      wr(32'h10, 32'd1);
      wait_irq("auto_period", 1, 2);
      wr(32'h00, 32'd0);

      xfer(1'b1, 32'h08, 32'hAABB_CCDD, 4'b0101, d);
      rd("reload_byte_lanes", 32'h08, 32'h00BB_00DD);

      // COUNT write landing exactly on a tick edge (fourth edge after EN commits).
      wr(32'h10, 32'd1);
      wr(32'h0C, 32'h0000_0100);
      wr(32'h04, 32'd3);
      wr(32'h00, 32'd1);
      wr(32'h18, 32'd0);
      wr(32'h0C, 32'h0000_0010);
      rd("count_write_beats_tick", 32'h0C, 32'h0000_0010);

      // STATUS clear landing on the expiry edge (eighth edge after EN commits).
      wr(32'h00, 32'd0);
      wr(32'h10, 32'd1);
      wr(32'h04, 32'd3);
      wr(32'h0C, 32'd1);
      wr(32'h08, 32'h0000_0020);
      wr(32'h00, 32'h0000_0007);
      wr(32'h18, 32'd0);
      wr(32'h18, 32'd0);
      wr(32'h18, 32'd0);
      wr(32'h10, 32'd1);
      rd("expire_beats_clear", 32'h10, 32'd1);
      check("expire_beats_clear_irq", 32'(irq), 32'd1);

      // Asynchronous reset while ack is high.
      @(negedge clk);
      bus.wbs_cyc_i = 1'b1;
      bus.wbs_stb_i = 1'b1;
      bus.wbs_we_i  = 1'b0;
      bus.wbs_adr_i = 32'h0C;
      @(posedge clk);
      #1;
      check("pre_reset_ack", 32'(bus.wbs_ack_o), 32'd1);
      check("pre_reset_irq", 32'(irq), 32'd1);
      rst_n = 1'b0;
      #1;
      check("async_reset_ack_irq", {31'd0, bus.wbs_ack_o | irq}, 32'd0);
      check("async_reset_dat", bus.wbs_dat_o, 32'd0);
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) rd($sformatf("post_reset_rd%0d", i), 32'(i * 4), 32'd0);
      check("post_reset_irq", 32'(irq), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/wb_timer.md
Name: wb_timer

Overview:
- Wishbone classic slave (responder) implementing a 32-bit down-counting timer with a programmable prescaler, optional auto-reload and a level interrupt.
- Attaches to the SoC Wishbone bus driven by the picorv32_wb master.
- irq_o drives one of the CPU's external interrupt lines (irq_5).

Parameters:
- PRESCALE_W, 16, width of the prescaler register and prescaler counter (1..32).

Ports:
- wb_clk_i  in  1  system clock; all logic on the rising edge.
- wb_rst_i  in  1  asynchronous, active-low reset (0 = reset asserted).
- wbs_adr_i  in  32  byte address; only bits [4:2] are decoded.
- wbs_dat_i  in  32  write data.
- wbs_dat_o  out  32  read data; valid while wbs_ack_o=1.
- wbs_we_i  in  1  1 = write.
- wbs_sel_i  in  4  byte lane enables for writes.
- wbs_stb_i  in  1  strobe.
- wbs_cyc_i  in  1  cycle valid.
- wbs_ack_o  out  1  single-cycle acknowledge.
- irq_o  out  1  interrupt, level, active-high.

Behaviour:
- Reset: all registers, counters, wbs_ack_o, wbs_dat_o and irq_o = 0. Reset is asynchronous assert, synchronous release. Reset mid-transfer drops the ack; the master retries.
- Handshake:
  - wbs_ack_o <= cyc & stb & ~ack, so the ack arrives exactly 1 cycle after the request.
  - Back-to-back requests give ack every other cycle. No wait states, no ERR/RTY.
  - A write commits on the clock edge that asserts ack. Read data is registered on the same edge.
  - wbs_dat_o = 0 when no ack.
- Register map (offset: field):
  - 0x00 CTRL: bit0 EN, bit1 AUTO, bit2 IRQ_EN; other bits read 0.
  - 0x04 PRESCALE: [PRESCALE_W-1:0]; tick period = PRESCALE+1 clocks.
  - 0x08 RELOAD: 32-bit reload value.
  - 0x0C COUNT: read gives the live counter; write loads the counter.
  - 0x10 STATUS: bit0 EXPIRED, sticky; writing 1 clears it.
  - 0x14-0x1C: reads return 0; writes are ignored.
- Byte lanes: the write updates only the lanes with wbs_sel_i set. STATUS clear uses lane 0 only.
- Prescaler:
  - While EN=1, pcnt increments each clock. When pcnt==PRESCALE, pcnt<=0 and a 1-cycle tick is produced.
  - EN=0 holds pcnt at 0.
  - Any write to PRESCALE resets pcnt to 0.
- On tick:
  - COUNT!=0: COUNT<=COUNT-1.
  - COUNT==0: EXPIRED<=1. If AUTO=1, COUNT<=RELOAD. If AUTO=0, EN<=0 and COUNT stays 0.
  - The full period with auto-reload is (RELOAD+1)*(PRESCALE+1) clocks.
- Simultaneous events:
  - A bus write to COUNT in a tick cycle: the bus value wins; the decrement is dropped.
  - A bus write to CTRL in the same cycle as an auto-stop: the bus value of EN wins.
  - A STATUS clear in the same cycle as a new expiry: the set wins, so EXPIRED=1.
- Wrap-around: COUNT never goes below 0. PRESCALE=0 gives a tick every enabled clock.
- irq_o = EXPIRED & IRQ_EN. It is the AND of two flops, with no combinational path from bus inputs.

Decomposition:
- Package wb_timer_pkg holds:
  - register offsets: ADDR_CTRL=3'd0, ADDR_PRESCALE=3'd1, ADDR_RELOAD=3'd2, ADDR_COUNT=3'd3, ADDR_STATUS=3'd4;
  - CTRL bit indices: EN=0, AUTO=1, IRQ_EN=2.
- Sub-module wb_timer_prescaler (inputs en, clr, div; outputs tick) contains the pcnt counter and tick generation.
- The bus decode, registers and down-counter stay in wb_timer.

Test Plan:
- Reset then read all 8 offsets: each returns 0, ack exactly 1 cycle after stb, irq_o=0.
- Write 0x04 with 0x0003, 0x0C with 0x00000002, then 0x00 with 0x5 (EN, IRQ_EN): EXPIRED and irq_o rise 12 clocks after the CTRL write commits; EN self-clears; COUNT reads 0.
- Write 0x08 with 5, 0x04 with 0, 0x00 with 0x7: irq_o asserts; clear via 0x10 with 0x1 → irq_o drops. EXPIRED re-sets every 6 clocks; COUNT cycles 5..0.
- Byte-lane write of 0xAABBCCDD to 0x08 with sel=4'b0101: RELOAD reads 0x00BB00DD.
- Write COUNT=0x10 in the exact tick cycle: COUNT reads 0x10, not 0x0F. STATUS clear coincident with expiry: EXPIRED reads 1.
- Assert wb_rst_i=0 mid-count with ack high: ack, irq_o and all registers return to 0 immediately, without waiting for a clock edge.
